// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
package pc_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t DEFAULT_FIRST_ADDR = '0;
  localparam addr_t DEFAULT_PC_INC     = 32'd4;

  // True when addr is a multiple of inc; inc must be a power of two.
  function automatic logic is_aligned(input addr_t addr, input addr_t inc);
    return (addr & (inc - addr_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/program_counter_if.sv
// Fetch-control <-> program counter bundle: redirect/stall requests in, pc values out.
interface program_counter_if;
  import pc_pkg::*;

  logic  stall;
  logic  load;
  addr_t target;
  addr_t pc;
  addr_t pc_next;
  logic  align_err;

  modport master (
    output stall,
    output load,
    output target,
    input  pc,
    input  pc_next,
    input  align_err
  );

  modport slave (
    input  stall,
    input  load,
    input  target,
    output pc,
    output pc_next,
    output align_err
  );

endinterface

// File: rtl/pc_adder.sv
// Combinational pc + pc_inc, wrapping modulo 2^ADDR_W.
module pc_adder
  import pc_pkg::*;
#(
  parameter addr_t pc_inc = DEFAULT_PC_INC
) (
  input  addr_t pc_i,
  output addr_t sum_o
);

  assign sum_o = pc_i + pc_inc;

endmodule

// File: rtl/program_counter.sv
// MIPS fetch-stage program counter with stall hold and redirect load.
// Optional misaligned-redirect rejection is compiled in with PC_ALIGN_CHECK_EN.
module program_counter
  import pc_pkg::*;
#(
  parameter addr_t first_address = DEFAULT_FIRST_ADDR,
  parameter addr_t pc_inc        = DEFAULT_PC_INC
) (
  input  logic             clk,
  input  logic             reset,
  program_counter_if.slave bus
);

  addr_t pc_q, pc_d;
  addr_t pc_plus;
  logic  load_ok;

  pc_adder #(
    .pc_inc(pc_inc)
  ) u_adder (
    .pc_i (pc_q),
    .sum_o(pc_plus)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
  logic align_err_q;

  assign misaligned = !is_aligned(bus.target, pc_inc);
  assign load_ok    = bus.load && !misaligned;

  // Sticky until reset; a rejected load falls through to the hold/increment path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err_q <= 1'b0;
    end else if (bus.load && misaligned) begin
      align_err_q <= 1'b1;
    end
  end

  assign bus.align_err = align_err_q;
`else
  assign load_ok       = bus.load;
  assign bus.align_err = 1'b0;
`endif

  always_comb begin
    pc_d = pc_plus;
    if (load_ok) begin
      pc_d = bus.target;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= first_address;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.pc_next = pc_plus;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a per-cycle reference model.
module tb_program_counter;

  localparam logic [31:0] FIRST = 32'h10;
  localparam logic [31:0] INC   = 32'd4;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  program_counter_if bus ();

  program_counter #(
    .first_address(FIRST),
    .pc_inc       (INC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  logic [31:0] m_pc  = FIRST;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc  = FIRST;
      m_err = 1'b0;
    end else if (bus.load && (!ALIGN_CHK || (bus.target % INC) == 0)) begin
      m_pc = bus.target;
    end else begin
      if (bus.load) m_err = 1'b1;
      if (!bus.stall) m_pc = 32'((64'(m_pc) + 64'(INC)) % 64'h1_0000_0000);
    end
  end

  always @(negedge clk) begin
    check("model_pc", bus.pc, m_pc);
    check("model_pc_next", bus.pc_next, 32'((64'(m_pc) + 64'(INC)) % 64'h1_0000_0000));
    check("model_align_err", {31'd0, bus.align_err}, {31'd0, m_err});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [31:0] tgt);
    bus.load   = ld;
    bus.stall  = st;
    bus.target = tgt;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    #1 reset = 1'b0;
    #2;
    check("reset_pc", bus.pc, 32'h10);
    check("reset_pc_next", bus.pc_next, 32'h14);
    check("reset_err", {31'd0, bus.align_err}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    step(); check("run1", bus.pc, 32'h14);
    step(); check("run2", bus.pc, 32'h18);
    step(); check("run3", bus.pc, 32'h1C);
    step(); check("run4", bus.pc, 32'h20);

    drive(1'b0, 1'b1, 32'h0);
    step(); check("stall1", bus.pc, 32'h20);
    step(); check("stall2", bus.pc, 32'h20);
    drive(1'b0, 1'b0, 32'h0);
    step(); check("unstall", bus.pc, 32'h24);

    drive(1'b1, 1'b1, 32'h100);
    step();
    check("redirect", bus.pc, 32'h100);
    check("redirect_next", bus.pc_next, 32'h104);
    drive(1'b0, 1'b0, 32'h0);
    step(); check("after_redirect", bus.pc, 32'h104);

    drive(1'b1, 1'b0, 32'hFFFF_FFFC);
    step(); check("wrap_load", bus.pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_next", bus.pc_next, 32'h4);
    check("wrap_no_err", {31'd0, bus.align_err}, 32'h0);

    drive(1'b1, 1'b0, 32'h40);
    step(); check("pc_40", bus.pc, 32'h40);
    drive(1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1 check("async_reset", bus.pc, 32'h10);
    drive(1'b1, 1'b0, 32'h200);
    step(); check("reset_hold1", bus.pc, 32'h10);
    step(); check("reset_hold2", bus.pc, 32'h10);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h20);
    step(); check("pc_20", bus.pc, 32'h20);

    drive(1'b1, 1'b0, 32'h102);
    step();
    if (ALIGN_CHK) begin
      check("misalign_pc", bus.pc, 32'h24);
      check("misalign_err", {31'd0, bus.align_err}, 32'h1);
    end else begin
      check("misalign_pc", bus.pc, 32'h102);
      check("misalign_err", {31'd0, bus.align_err}, 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0);
    step(); step();
    check("err_sticky", {31'd0, bus.align_err}, {31'd0, ALIGN_CHK});
    #2 reset = 1'b0;
    #1 check("err_cleared", {31'd0, bus.align_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(); check("final_run", bus.pc, 32'h14);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
